inst_fetch_queue: RTL and testbench

Next-generation instruction fetch stage. It generates sequential fetch PCs itself and keeps up to MAX_OUTSTANDING read requests in flight on the instruction bus. Returned words are buffered in a DEPTH-entry in-order fetch queue that feeds decode. Supports redirect/flush with discard of stale in-flight responses; sits between the PC/branch unit and decode.

---
 rtl/inst_fetch_queue.sv | 187 ++++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Instruction fetch stage. Generates sequential word-address fetch PCs, keeps
// up to MAX_OUTSTANDING reads in flight on the instruction bus, and buffers
// returned words in a DEPTH-entry in-order queue that feeds decode. A flush
// redirects the fetch PC, clears the queue and marks every in-flight read as
// stale so its response is discarded when it comes back.
//
// Handshakes:
//   bus     : bus_read_o is a request strobe that the memory always accepts in
//             the same cycle; bus_ready_i pulses once per response, in request
//             order. There is no request back-pressure.
//   decode  : inst_valid_o is the valid of the head entry; !stall_i is the
//             ready. The head transfers on a cycle where inst_valid_o=1 and
//             stall_i=0, and only then does the queue pop.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   stall_i                  decode cannot accept this cycle
//   flush_i, redirect_pc_i   redirect; redirect_pc_i sampled when flush_i=1
//   bus_addr_o, bus_read_o   read request (word address, strobe)
//   bus_write_o              tied 0
//   bus_byteSel_o            tied 4'b1111
//   bus_dataQ_i, bus_ready_i read response
//   inst_valid_o/pc_o/inst_o registered queue head
//   outstanding_o            number of reads in flight
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int                 ADDR_W          = 30,
  parameter int                 DATA_W          = 32,
  parameter int                 DEPTH           = 4,
  parameter int                 MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC        = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 stall_i,
  input  logic                                 flush_i,
  input  logic [ADDR_W-1:0]                    redirect_pc_i,
  output logic [ADDR_W-1:0]                    bus_addr_o,
  output logic                                 bus_read_o,
  output logic                                 bus_write_o,
  output logic [3:0]                           bus_byteSel_o,
  input  logic [DATA_W-1:0]                    bus_dataQ_i,
  input  logic                                 bus_ready_i,
  output logic                                 inst_valid_o,
  output logic [ADDR_W-1:0]                    inst_pc_o,
  output logic [DATA_W-1:0]                    inst_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int QAW = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW  = CW + 1;

  // Fetch PC and request bookkeeping
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] addr_q;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     drop;

  // PC FIFO: the address of each in-flight read, popped as responses arrive
  logic [ADDR_W-1:0] pc_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]     pf_wr;
  logic [PW-1:0]     pf_rd;

  // Fetch queue storage
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [QAW-1:0]    q_head;
  logic [QAW-1:0]    q_tail;
  logic [CW-1:0]     q_count;

  logic              issue;
  logic              push;
  logic              pop;
  logic [SW-1:0]     credits_used;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CW-1:0]     q_count_nx;
  logic [CW-1:0]     q_remain;
  logic [QAW-1:0]    q_head_nx;

  function automatic logic [PW-1:0] pf_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Every live (non-dropped) in-flight read owns a queue slot, so a response
  // can always be written without checking for space.
  assign credits_used = SW'(q_count) + SW'(outstanding) - SW'(drop);

  // rst gating keeps the strobe low while reset is held, even though the
  // cleared state would otherwise permit an issue.
  assign issue = rst && !flush_i
                 && (outstanding < OW'(MAX_OUTSTANDING))
                 && (credits_used < SW'(DEPTH));

  assign push       = bus_ready_i && (drop == '0) && !flush_i;
  assign pop        = inst_valid_o && !stall_i && !flush_i;
  assign rsp_pc     = pc_fifo[pf_rd];
  assign q_count_nx = q_count + CW'(push) - CW'(pop);
  assign q_remain   = q_count - CW'(pop);
  assign q_head_nx  = q_head + QAW'(pop);

  assign bus_read_o    = issue;
  assign bus_addr_o    = issue ? fetch_pc : addr_q;
  assign bus_write_o   = 1'b0;
  assign bus_byteSel_o = 4'b1111;
  assign outstanding_o = outstanding;

  // Storage arrays carry no reset; their contents are qualified by the
  // pointers and counts below.
  always_ff @(posedge clk) begin
    if (issue) pc_fifo[pf_wr] <= fetch_pc;
    if (push) begin
      q_pc[q_tail]   <= rsp_pc;
      q_data[q_tail] <= bus_dataQ_i;
    end
  end

  // Request side: fetch PC, in-flight count, drop count, PC FIFO pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      addr_q      <= '0;
      outstanding <= '0;
      drop        <= '0;
      pf_wr       <= '0;
      pf_rd       <= '0;
    end else begin
      outstanding <= outstanding + OW'(issue) - OW'(bus_ready_i);
      if (issue) begin
        pf_wr  <= pf_inc(pf_wr);
        addr_q <= fetch_pc;
      end
      if (bus_ready_i) pf_rd <= pf_inc(pf_rd);

      if (flush_i) begin
        fetch_pc <= redirect_pc_i;
        // Everything still in flight after this cycle is stale, including
        // reads already marked for dropping, so the new drop count is simply
        // what remains outstanding. A response in this cycle is discarded.
        if (outstanding == '0) drop <= '0;
        else                   drop <= outstanding - OW'(bus_ready_i);
      end else begin
        if (issue) fetch_pc <= fetch_pc + ADDR_W'(1);
        if (bus_ready_i && (drop != '0)) drop <= drop - OW'(1);
      end
    end
  end

  // Queue side: pointers, count and the registered head outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_head       <= '0;
      q_tail       <= '0;
      q_count      <= '0;
      inst_valid_o <= 1'b0;
      inst_pc_o    <= '0;
      inst_o       <= '0;
    end else if (flush_i) begin
      q_head       <= '0;
      q_tail       <= '0;
      q_count      <= '0;
      inst_valid_o <= 1'b0;
    end else begin
      if (push) q_tail <= q_tail + QAW'(1);
      q_head       <= q_head_nx;
      q_count      <= q_count_nx;
      inst_valid_o <= (q_count_nx != '0);
      if (q_count_nx != '0) begin
        // If nothing older survives this cycle, the new head is the word
        // arriving now; otherwise it is already in storage.
        if (q_remain == '0) begin
          inst_pc_o <= rsp_pc;
          inst_o    <= bus_dataQ_i;
        end else begin
          inst_pc_o <= q_pc[q_head_nx];
          inst_o    <= q_data[q_head_nx];
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  localparam int                ADDR_W   = 30;
  localparam int                DATA_W   = 32;
  localparam int                DEPTH    = 4;
  localparam int                MAX_OUT  = 2;
  localparam logic [ADDR_W-1:0] RESET_PC = 30'h100;
  localparam int                OW       = $clog2(MAX_OUT + 1);

  logic              clk;
  logic              rst;
  logic              stall_i;
  logic              flush_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic [ADDR_W-1:0] bus_addr_o;
  logic              bus_read_o;
  logic              bus_write_o;
  logic [3:0]        bus_byteSel_o;
  logic [DATA_W-1:0] bus_dataQ_i;
  logic              bus_ready_i;
  logic              inst_valid_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic [DATA_W-1:0] inst_o;
  logic [OW-1:0]     outstanding_o;

  inst_fetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_pc_i(redirect_pc_i), .bus_addr_o(bus_addr_o),
    .bus_read_o(bus_read_o), .bus_write_o(bus_write_o),
    .bus_byteSel_o(bus_byteSel_o), .bus_dataQ_i(bus_dataQ_i),
    .bus_ready_i(bus_ready_i), .inst_valid_o(inst_valid_o),
    .inst_pc_o(inst_pc_o), .inst_o(inst_o), .outstanding_o(outstanding_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  typedef struct { logic [ADDR_W-1:0] addr; int due; } mem_req_t;
  typedef struct { logic [ADDR_W-1:0] pc; bit stale; } fly_t;

  mem_req_t                   mem_q[$];   // memory: accepted reads awaiting response
  fly_t                       fly_q[$];   // reads in flight, oldest first
  logic [ADDR_W+DATA_W-1:0]   exp_q[$];   // expected fetch queue contents {pc, data}
  logic [ADDR_W-1:0]          m_pc;       // next fetch address
  int cyc, lat, jit, last_due;
  int n_tests, n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] x;
    x = 32'(a);
    return (x * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic bit will_respond();
    return (mem_q.size() > 0) && (mem_q[0].due <= cyc);
  endfunction

  task automatic model_reset();
    mem_q.delete();
    fly_q.delete();
    exp_q.delete();
    m_pc     = RESET_PC;
    last_due = 0;
  endtask

  // One clock cycle: drive inputs (called at posedge+1), check at negedge,
  // advance the model, return at the next posedge+1.
  task automatic cycle(input bit st, input bit fl, input logic [ADDR_W-1:0] rpc);
    int  live;
    int  due;
    bit  exp_read;
    bit  rdy;
    fly_t r;
    logic [ADDR_W+DATA_W-1:0] head;
    stall_i       = st;
    flush_i       = fl;
    redirect_pc_i = rpc;
    rdy = will_respond();
    if (rdy) begin
      bus_ready_i = 1'b1;
      bus_dataQ_i = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      bus_ready_i = 1'b0;
      bus_dataQ_i = $urandom;
    end

    @(negedge clk);
    live = 0;
    foreach (fly_q[i]) if (!fly_q[i].stale) live++;
    exp_read = !fl && (fly_q.size() < MAX_OUT) && ((exp_q.size() + live) < DEPTH);
    check("bus_read", 64'(bus_read_o), 64'(exp_read));
    if (exp_read && bus_read_o) check("bus_addr", 64'(bus_addr_o), 64'(m_pc));
    check("outstanding", 64'(outstanding_o), 64'(fly_q.size()));
    check("inst_valid", 64'(inst_valid_o), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0 && inst_valid_o) begin
      head = exp_q[0];
      check("inst_pc", 64'(inst_pc_o), 64'(head[ADDR_W+DATA_W-1:DATA_W]));
      check("inst", 64'(inst_o), 64'(head[DATA_W-1:0]));
    end

    // Memory accepts whatever the DUT actually requested
    if (bus_read_o) begin
      due = cyc + lat + int'($urandom_range(0, jit));
      if (due < last_due) due = last_due;
      last_due = due;
      mem_q.push_back('{bus_addr_o, due});
    end

    // Model update for this clock edge
    if (exp_q.size() != 0 && !fl && !st) void'(exp_q.pop_front());
    if (rdy) begin
      check("rsp_has_request", 64'(fly_q.size() != 0), 64'(1));
      if (fly_q.size() != 0) begin
        r = fly_q.pop_front();
        if (!fl && !r.stale) begin
          exp_q.push_back({r.pc, mem_word(r.pc)});
          check("queue_credit", 64'(exp_q.size() <= DEPTH), 64'(1));
        end
      end
    end
    if (fl) begin
      exp_q.delete();
      foreach (fly_q[i]) fly_q[i].stale = 1'b1;
      m_pc = rpc;
    end else if (exp_read) begin
      fly_q.push_back('{m_pc, 1'b0});
      m_pc = m_pc + ADDR_W'(1);
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    logic [ADDR_W-1:0] rpc;
    n_tests = 0; n_fail = 0; cyc = 0; lat = 1; jit = 0;
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_pc_i = '0;
    bus_ready_i = 1'b0; bus_dataQ_i = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_read", 64'(bus_read_o), 64'(0));
    check("rst_inst_valid", 64'(inst_valid_o), 64'(0));
    check("rst_inst_pc", 64'(inst_pc_o), 64'(0));
    check("rst_inst", 64'(inst_o), 64'(0));
    check("rst_outstanding", 64'(outstanding_o), 64'(0));
    check("bus_write", 64'(bus_write_o), 64'(0));
    check("bus_byte_sel", 64'(bus_byteSel_o), 64'(4'hF));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Zero-wait memory, no stall: back-to-back from RESET_PC
    lat = 1; jit = 0;
    repeat (20) cycle(1'b0, 1'b0, '0);

    // Stall fills the queue, release drains it in order
    repeat (12) cycle(1'b1, 1'b0, '0);
    repeat (10) cycle(1'b0, 1'b0, '0);

    // Five-cycle memory latency
    lat = 5;
    repeat (40) begin
      cycle(1'b0, 1'b0, '0);
      check("max_outstanding", 64'(outstanding_o <= MAX_OUT), 64'(1));
    end

    // Flush with two reads in flight
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (fly_q.size() == 2) found = 1'b1;
      else cycle(1'b0, 1'b0, '0);
    end
    check("t4_two_in_flight", 64'(found), 64'(1));
    cycle(1'b0, 1'b1, 30'h200);
    repeat (30) cycle(1'b0, 1'b0, '0);

    // Flush in the same cycle as the only outstanding response
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (will_respond() && fly_q.size() == 1) begin
        cycle(1'b1, 1'b1, 30'h300);
        found = 1'b1;
      end else begin
        cycle(1'b1, 1'b0, '0);
      end
    end
    check("t5_flush_on_ready", 64'(found), 64'(1));
    repeat (20) cycle(1'b0, 1'b0, '0);

    // Asynchronous reset with three queued entries
    lat = 1;
    cycle(1'b1, 1'b1, 30'h180);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (exp_q.size() == 3) found = 1'b1;
      else cycle(1'b1, 1'b0, '0);
    end
    check("t6_three_entries", 64'(found), 64'(1));
    rst = 1'b0;
    #2;
    check("t6_async_bus_read", 64'(bus_read_o), 64'(0));
    check("t6_async_inst_valid", 64'(inst_valid_o), 64'(0));
    check("t6_async_outstanding", 64'(outstanding_o), 64'(0));
    bus_ready_i = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc += 2;
    rst = 1'b1;
    repeat (10) cycle(1'b0, 1'b0, '0);

    // Randomized traffic: stalls, latency jitter, flushes, PC wrap
    for (int blk = 0; blk < 15; blk++) begin
      lat = int'($urandom_range(1, 6));
      jit = int'($urandom_range(0, 2));
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 3) == 0) rpc = '1 - ADDR_W'($urandom_range(0, 3));
        else                           rpc = ADDR_W'($urandom);
        cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0), rpc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
